// File: rtl/w5300_transmitter.sv
// Streams a payload from an external synchronous TX buffer into a W5300 socket TX FIFO,
// waiting for enough free space, then issues SEND and waits for the SEND_OK interrupt.
module w5300_transmitter #(
    parameter logic [2:0] N                   = 3'd0,
    parameter int         ETH_TX_BUFFER_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           tx_req,
    input  logic [15:0]                    tx_bytes,
    input  logic                           tx_irq,
    output logic                           tx_busy,
    output logic [ETH_TX_BUFFER_WIDTH-1:0] tx_buffer_addr,
    input  logic [15:0]                    tx_buffer_data,
    output logic                           tx_done,
    output logic [10:0]                    addr,
    output logic [15:0]                    wr_data,
    input  logic [15:0]                    rd_data,
    input  logic                           op_state
);

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    localparam logic [9:0] SN_CR       = 10'h002;
    localparam logic [9:0] SN_TX_WRSR2 = 10'h022;
    localparam logic [9:0] SN_TX_FSR0  = 10'h024;
    localparam logic [9:0] SN_TX_FSR2  = 10'h026;
    localparam logic [9:0] SN_TX_FIFOR = 10'h02e;
    localparam logic [9:0] IDLE_REG    = 10'h3fe;
    localparam logic [15:0] SN_CR_SEND = 16'h0020;

    // Socket register block n lives at 0x200 + n*0x40 in the W5300 map.
    function automatic logic [9:0] get_socket_n_reg(input logic [9:0] offset);
        return 10'h200 + {1'b0, N, 6'b000000} + offset;
    endfunction

    typedef enum logic [3:0] {
        Idle,
        ReadFsr0,
        ReadFsr2,
        CheckFsr,
        Fetch,
        WriteFifo,
        WriteSize,
        Send,
        WaitSendOk,
        PostSend
    } state_t;

    state_t                         state_q, state_d;
    logic [15:0]                    len_q, len_d;
    logic [15:0]                    wordCount_q, wordCount_d;
    logic [15:0]                    wordCnt_q, wordCnt_d;
    logic [16:0]                    free_q, free_d;
    logic [ETH_TX_BUFFER_WIDTH-1:0] bufAddr_q, bufAddr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= Idle;
            len_q       <= '0;
            wordCount_q <= '0;
            wordCnt_q   <= '0;
            free_q      <= '0;
            bufAddr_q   <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wordCount_q <= wordCount_d;
            wordCnt_q   <= wordCnt_d;
            free_q      <= free_d;
            bufAddr_q   <= bufAddr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wordCount_d = wordCount_q;
        wordCnt_d   = wordCnt_q;
        free_d      = free_q;
        bufAddr_d   = bufAddr_q;
        addr        = {CMD_RD, IDLE_REG};
        wr_data     = 16'h0000;
        tx_done     = 1'b0;

        case (state_q)
            Idle: begin
                wordCnt_d = '0;
                bufAddr_d = '0;
                if (tx_req && op_state && (tx_bytes != 16'h0000)) begin
                    len_d       = tx_bytes;
                    wordCount_d = (tx_bytes + {15'b0, tx_bytes[0]}) >> 1;
                    state_d     = ReadFsr0;
                end
            end
            ReadFsr0: begin
                addr = {CMD_RD, get_socket_n_reg(SN_TX_FSR0)};
                if (op_state) begin
                    free_d[16] = rd_data[0];
                    state_d    = ReadFsr2;
                end
            end
            ReadFsr2: begin
                addr = {CMD_RD, get_socket_n_reg(SN_TX_FSR2)};
                if (op_state) begin
                    free_d[15:0] = rd_data;
                    state_d      = CheckFsr;
                end
            end
            CheckFsr: begin
                state_d = (free_q >= {1'b0, len_q}) ? Fetch : ReadFsr0;
            end
            Fetch: begin
                state_d = WriteFifo;
            end
            WriteFifo: begin
                // An odd final byte goes out as a whole word; WRSR tells the chip to drop the pad.
                addr    = {CMD_WR, get_socket_n_reg(SN_TX_FIFOR)};
                wr_data = tx_buffer_data;
                if (op_state) begin
                    wordCnt_d = wordCnt_q + 16'd1;
                    bufAddr_d = bufAddr_q + 1'b1;
                    state_d   = ((wordCnt_q + 16'd1) == wordCount_q) ? WriteSize : Fetch;
                end
            end
            WriteSize: begin
                addr    = {CMD_WR, get_socket_n_reg(SN_TX_WRSR2)};
                wr_data = len_q;
                if (op_state) begin
                    state_d = Send;
                end
            end
            Send: begin
                addr    = {CMD_WR, get_socket_n_reg(SN_CR)};
                wr_data = SN_CR_SEND;
                if (op_state) begin
                    state_d = WaitSendOk;
                end
            end
            WaitSendOk: begin
                if (tx_irq) begin
                    state_d = PostSend;
                end
            end
            PostSend: begin
                tx_done = 1'b1;
                state_d = Idle;
            end
            default: begin
                state_d = Idle;
            end
        endcase
    end

    assign tx_busy        = (state_q != Idle);
    assign tx_buffer_addr = bufAddr_q;

endmodule

// File: tb/tb_w5300_transmitter.sv
// Bench for w5300_transmitter: a randomly stalling bus model logs every completed command,
// and a transaction-level reference model predicts the full command sequence per transfer.
module tb_w5300_transmitter;

    localparam logic [10:0] CMD_IDLE  = 11'h3fe;
    localparam logic [10:0] CMD_FSR0  = 11'h224;
    localparam logic [10:0] CMD_FSR2  = 11'h226;
    localparam logic [10:0] CMD_FIFOR = 11'h62e;
    localparam logic [10:0] CMD_WRSR2 = 11'h622;
    localparam logic [10:0] CMD_CR    = 11'h602;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_req = 1'b0;
    logic [15:0] tx_bytes = 16'h0000;
    logic        tx_irq = 1'b0;
    logic        tx_busy;
    logic [15:0] tx_buffer_addr;
    logic [15:0] tx_buffer_data = 16'h0000;
    logic        tx_done;
    logic [10:0] addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data = 16'h0000;
    logic        op_state = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:255];
    logic [15:0] fsr2Tab [0:15];
    logic [15:0] fsr0Val = 16'h0000;
    int          pollIdx = 0;
    int          doneCount = 0;
    logic [15:0] addrAtDone = 16'h0000;
    bit          prevDone = 1'b0;
    bit          crSeen = 1'b0;
    bit          irqNoise = 1'b0;
    bit          irqForce = 1'b0;
    logic [10:0] logAddr [$];
    logic [15:0] logData [$];

    typedef struct {
        string       name;
        int          len;
        logic [15:0] fsr0;
        int          lowPolls;
        logic [15:0] lowVal;
        logic [15:0] highVal;
        int          expWrites;
        int          expPolls;
    } vec_t;

    vec_t vecs [6];

    w5300_transmitter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tx_req         (tx_req),
        .tx_bytes       (tx_bytes),
        .tx_irq         (tx_irq),
        .tx_busy        (tx_busy),
        .tx_buffer_addr (tx_buffer_addr),
        .tx_buffer_data (tx_buffer_data),
        .tx_done        (tx_done),
        .addr           (addr),
        .wr_data        (wr_data),
        .rd_data        (rd_data),
        .op_state       (op_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tx_buffer_data <= mem[tx_buffer_addr[7:0]];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bus model and monitor: stalls randomly, answers FSR reads, logs completed commands.
    always @(negedge clk) begin
        op_state = ($urandom_range(0, 2) != 0);
        tx_irq   = irqForce | (irqNoise & ($urandom_range(0, 2) == 0));
        if (addr == CMD_FSR0)      rd_data = fsr0Val;
        else if (addr == CMD_FSR2) rd_data = fsr2Tab[(pollIdx > 15) ? 15 : pollIdx];
        else                       rd_data = 16'hbeef;
        if (prevDone) checkOutput("busyAfterDone", {31'b0, tx_busy}, 32'd0);
        prevDone = tx_done;
        if (tx_done) begin
            doneCount++;
            addrAtDone = tx_buffer_addr;
        end
        if (op_state && (addr != CMD_IDLE)) begin
            logAddr.push_back(addr);
            logData.push_back(wr_data);
            if (addr == CMD_FSR2) pollIdx++;
            if (addr == CMD_CR) begin
                crSeen   = 1'b1;
                irqNoise = 1'b0;
            end
        end
    end

    function automatic int expectedPolls(input logic [15:0] f0, input int lowPolls,
                                         input logic [15:0] lowVal, input logic [15:0] highVal,
                                         input int len);
        for (int p = 0; p < 16; p++) begin
            int freeSpace;
            freeSpace = int'(f0[0]) * 65536 + int'((p < lowPolls) ? lowVal : highVal);
            if (freeSpace >= len) return p + 1;
        end
        return 16;
    endfunction

    function automatic int countCmd(input logic [10:0] cmd);
        int n = 0;
        foreach (logAddr[i]) if (logAddr[i] == cmd) n++;
        return n;
    endfunction

    task automatic prepare(input logic [15:0] f0, input int lowPolls,
                           input logic [15:0] lowVal, input logic [15:0] highVal, input bit fixedData);
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        if (fixedData) begin
            mem[0] = 16'ha1b2;
            mem[1] = 16'hc3d4;
        end
        for (int p = 0; p < 16; p++) fsr2Tab[p] = (p < lowPolls) ? lowVal : highVal;
        fsr0Val   = f0;
        pollIdx   = 0;
        doneCount = 0;
        crSeen    = 1'b0;
        irqForce  = 1'b0;
        logAddr.delete();
        logData.delete();
    endtask

    task automatic startRequest(input string name, input int len);
        int cyc = 0;
        tx_bytes = 16'(len);
        tx_req   = 1'b1;
        while (!tx_busy && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        tx_req   = 1'b0;
        tx_bytes = 16'($urandom);
        checkOutput({name, " started"}, {31'b0, tx_busy}, 32'd1);
    endtask

    task automatic applyStimulus(input string name, input int len, input logic [15:0] f0,
                                 input int lowPolls, input logic [15:0] lowVal,
                                 input logic [15:0] highVal, input int expWrites,
                                 input int expPolls, input bit fixedData);
        logic [10:0] eAddr [$];
        logic [15:0] eData [$];
        bit          eChk [$];
        int          cyc;
        int          polls;
        prepare(f0, lowPolls, lowVal, highVal, fixedData);
        irqNoise = 1'b1;
        polls = expectedPolls(f0, lowPolls, lowVal, highVal, len);
        for (int p = 0; p < polls; p++) begin
            eAddr.push_back(CMD_FSR0); eData.push_back(16'h0); eChk.push_back(1'b0);
            eAddr.push_back(CMD_FSR2); eData.push_back(16'h0); eChk.push_back(1'b0);
        end
        for (int w = 0; w < (len + 1) / 2; w++) begin
            eAddr.push_back(CMD_FIFOR); eData.push_back(mem[w]); eChk.push_back(1'b1);
        end
        eAddr.push_back(CMD_WRSR2); eData.push_back(16'(len));  eChk.push_back(1'b1);
        eAddr.push_back(CMD_CR);    eData.push_back(16'h0020); eChk.push_back(1'b1);

        startRequest(name, len);
        if (!tx_busy) return;
        cyc = 0;
        while (!crSeen && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput({name, " send issued"}, {31'b0, crSeen}, 32'd1);
        if (!crSeen) return;
        checkOutput({name, " no done before irq"}, doneCount, 0);
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 irqForce = 1'b1;
        @(posedge clk);
        #1 irqForce = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput({name, " done pulses"}, doneCount, 1);
        checkOutput({name, " buffer addr at done"}, addrAtDone, expWrites);
        checkOutput({name, " FIFOR writes"}, countCmd(CMD_FIFOR), expWrites);
        checkOutput({name, " FSR polls"}, countCmd(CMD_FSR2), expPolls);
        checkOutput({name, " command count"}, logAddr.size(), eAddr.size());
        for (int i = 0; i < eAddr.size() && i < logAddr.size(); i++) begin
            checkOutput($sformatf("%s cmd%0d", name, i), logAddr[i], eAddr[i]);
            if (eChk[i]) checkOutput($sformatf("%s data%0d", name, i), logData[i], eData[i]);
        end
    endtask

    initial begin
        vecs[0] = '{"basic4",   4, 16'h0000, 0, 16'h0000, 16'h1000, 2, 1};
        vecs[1] = '{"odd5",     5, 16'h0000, 0, 16'h0000, 16'h1000, 3, 1};
        vecs[2] = '{"poll3",    8, 16'hfffe, 3, 16'h0002, 16'h0100, 4, 4};
        vecs[3] = '{"exactFit", 8, 16'h0000, 2, 16'h0007, 16'h0008, 4, 3};
        vecs[4] = '{"fsr0Bit",  6, 16'h0001, 0, 16'h0000, 16'h0000, 3, 1};
        vecs[5] = '{"len1",     1, 16'h0000, 1, 16'h0000, 16'h0001, 1, 2};

        #3;
        checkOutput("reset busy", {31'b0, tx_busy}, 32'd0);
        checkOutput("reset done", {31'b0, tx_done}, 32'd0);
        checkOutput("reset addr", addr, CMD_IDLE);
        checkOutput("reset wr_data", wr_data, 16'h0000);
        checkOutput("reset buffer addr", tx_buffer_addr, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].name, vecs[v].len, vecs[v].fsr0, vecs[v].lowPolls,
                          vecs[v].lowVal, vecs[v].highVal, vecs[v].expWrites,
                          vecs[v].expPolls, v == 0);
        end

        // Zero-length requests must be dropped without touching the bus.
        prepare(16'h0000, 0, 16'h0000, 16'h1000, 1'b0);
        tx_bytes = 16'h0000;
        tx_req   = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            checkOutput("zeroLen busy", {31'b0, tx_busy}, 32'd0);
            checkOutput("zeroLen addr", addr, CMD_IDLE);
        end
        tx_req = 1'b0;
        checkOutput("zeroLen done", doneCount, 0);
        checkOutput("zeroLen commands", logAddr.size(), 0);

        // Reset in the middle of the FIFO phase, then a clean restart.
        begin
            int cyc = 0;
            prepare(16'h0000, 0, 16'h0000, 16'h1000, 1'b0);
            irqNoise = 1'b0;
            startRequest("midReset", 8);
            while (countCmd(CMD_FIFOR) < 2 && cyc < 2000) begin
                @(posedge clk); #1;
                cyc++;
            end
            @(posedge clk); #1;
            checkOutput("midReset addr before", tx_buffer_addr, 16'd2);
            rst_n = 1'b0;
            #1;
            checkOutput("midReset busy", {31'b0, tx_busy}, 32'd0);
            checkOutput("midReset done", {31'b0, tx_done}, 32'd0);
            checkOutput("midReset addr", addr, CMD_IDLE);
            checkOutput("midReset wr_data", wr_data, 16'h0000);
            checkOutput("midReset buffer addr", tx_buffer_addr, 16'h0000);
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            applyStimulus("afterReset", 8, 16'h0000, 0, 16'h0000, 16'h0100, 4, 1, 1'b0);
        end

        for (int r = 0; r < 6; r++) begin
            int          len;
            int          lowPolls;
            logic [15:0] f0;
            logic [15:0] lowVal;
            logic [15:0] highVal;
            len      = $urandom_range(1, 40);
            f0       = 16'($urandom);
            lowPolls = $urandom_range(0, 3);
            lowVal   = 16'($urandom_range(0, len - 1));
            highVal  = 16'($urandom_range(len, 16'hffff));
            applyStimulus($sformatf("rand%0d", r), len, f0, lowPolls, lowVal, highVal,
                          (len + 1) / 2, expectedPolls(f0, lowPolls, lowVal, highVal, len), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
